// File: rtl/v5_pulse_gen_pkg.sv
// Shared sample width, pulse-generator FSM encoding and default shaping constants.
// Sample format matches the filter input so the generator can drive it directly.
package v5_param;

    localparam int SIZE_ADC_DATA   = 12;
    localparam int DECAY_SHIFT_DEF = 5;
    localparam int FRAC_BITS_DEF   = 8;
    localparam int MAX_LEN_DEF     = 1024;

    typedef logic signed [SIZE_ADC_DATA-1:0] adc_t;
    typedef logic        [SIZE_ADC_DATA-2:0] amp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DECAY = 1'b1
    } state_t;

endpackage

// File: rtl/v5_pulse_gen_if.sv
// Pulse request / synthetic ADC sample bundle between a stimulus controller and the generator.
// Unflow-controlled: start is a one-cycle request, the sample stream runs every cycle.
interface v5_pulse_gen_if;
    import v5_param::*;

    logic start;
    amp_t amplitude;
    adc_t baseline;
    adc_t adc_data;
    logic busy;
    logic pulse_done;
    logic pileup;

    modport master (
        output start, amplitude, baseline,
        input  adc_data, busy, pulse_done, pileup
    );

    modport slave (
        input  start, amplitude, baseline,
        output adc_data, busy, pulse_done, pileup
    );

endinterface

// File: rtl/v5_pulse_gen.sv
// Exponential-decay pulse synthesiser: sample = baseline + acc, acc shrinks by acc>>DECAY_SHIFT per cycle.
// Latency 1 from start to first sample; no backpressure, a start while busy piles up onto the tail.
module v5_pulse_gen
    import v5_param::*;
#(
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int MAX_LEN     = MAX_LEN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    v5_pulse_gen_if.slave bus
);

    localparam int ACC_W     = SIZE_ADC_DATA + FRAC_BITS;
    localparam int CNT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int OUT_W     = SIZE_ADC_DATA + 2;
    localparam int OUT_MAX_I = (1 << (SIZE_ADC_DATA - 1)) - 1;
    localparam int OUT_MIN_I = -(1 << (SIZE_ADC_DATA - 1));

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAX_LEN - 1);
    localparam logic signed [OUT_W-1:0] OUT_MAX  = OUT_W'(OUT_MAX_I);
    localparam logic signed [OUT_W-1:0] OUT_MIN  = OUT_W'(OUT_MIN_I);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    adc_t             r_adc;
    logic             r_busy;
    logic             r_done;
    logic             r_pileup;

    logic [ACC_W-1:0]           w_load;
    logic [ACC_W-1:0]           w_decayed;
    logic [ACC_W:0]             w_sum;
    logic [ACC_W-1:0]           w_piled;
    logic [ACC_W-1:0]           w_acc_next;
    logic [CNT_W-1:0]           w_cnt_next;
    state_t                     w_state_next;
    logic                       w_done;
    logic                       w_pileup;
    logic [SIZE_ADC_DATA-1:0]   w_int;
    logic signed [OUT_W-1:0]    w_out_wide;
    adc_t                       w_out_sat;

    assign w_load    = ACC_W'(bus.amplitude) << FRAC_BITS;
    assign w_decayed = r_acc - (r_acc >> DECAY_SHIFT);
    assign w_sum     = {1'b0, w_decayed} + {1'b0, w_load};
    assign w_piled   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

    always_comb begin
        w_acc_next   = '0;
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
        w_done       = 1'b0;
        w_pileup     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_acc_next   = w_load;
                    w_state_next = ST_DECAY;
                end
            end
            ST_DECAY: begin
                // A new start outranks both end conditions, so piled pulses never emit pulse_done.
                if (bus.start) begin
                    w_acc_next   = w_piled;
                    w_state_next = ST_DECAY;
                    w_pileup     = 1'b1;
                end else if ((w_decayed[ACC_W-1:FRAC_BITS] == '0) || (r_cnt == CNT_LAST)) begin
                    w_done = 1'b1;
                end else begin
                    w_acc_next   = w_decayed;
                    w_cnt_next   = r_cnt + 1'b1;
                    w_state_next = ST_DECAY;
                end
            end
            default: ;
        endcase
    end

    // Output is formed from the next accumulator value so the sample lands on the same edge as acc.
    assign w_int      = w_acc_next[ACC_W-1:FRAC_BITS];
    assign w_out_wide = OUT_W'(bus.baseline) + OUT_W'($signed({1'b0, w_int}));
    assign w_out_sat  = (w_out_wide > OUT_MAX) ? OUT_MAX[SIZE_ADC_DATA-1:0] :
                        (w_out_wide < OUT_MIN) ? OUT_MIN[SIZE_ADC_DATA-1:0] :
                                                 w_out_wide[SIZE_ADC_DATA-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_adc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pileup <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_adc    <= w_out_sat;
            r_busy   <= (w_state_next == ST_DECAY);
            r_done   <= w_done;
            r_pileup <= w_pileup;
        end
    end

    assign bus.adc_data   = r_adc;
    assign bus.busy       = r_busy;
    assign bus.pulse_done = r_done;
    assign bus.pileup     = r_pileup;

endmodule

// File: tb/tb_v5_pulse_gen.sv
// Scoreboard bench for v5_pulse_gen: default-parameter instance plus a MAX_LEN=16 instance for timeout.
module tb_v5_pulse_gen;
    import v5_param::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    v5_pulse_gen_if a_if ();
    v5_pulse_gen_if b_if ();

    v5_pulse_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    v5_pulse_gen #(.MAX_LEN(16)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    typedef struct {
        bit    chk_adc;
        adc_t  adc;
        bit    busy;
        bit    done;
        bit    pileup;
        string name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare(input string who, input exp_t e, input adc_t adc,
                           input logic busy, input logic done, input logic pile);
        if (e.chk_adc) check({who, ".", e.name, ".adc_data"}, int'(adc), int'(e.adc));
        check({who, ".", e.name, ".busy"},       int'(busy), int'(e.busy));
        check({who, ".", e.name, ".pulse_done"}, int'(done), int'(e.done));
        check({who, ".", e.name, ".pileup"},     int'(pile), int'(e.pileup));
    endtask

    // Monitors: each pops the expectation queued for the edge that just happened.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            compare("A", e, a_if.adc_data, a_if.busy, a_if.pulse_done, a_if.pileup);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            compare("B", e, b_if.adc_data, b_if.busy, b_if.pulse_done, b_if.pileup);
        end
    end

    task automatic drive(input bit to_b, input bit rst, input bit st, input int amp, input int base,
                         input bit ca, input int ea, input bit eb, input bit ed, input bit ep,
                         input string nm);
        exp_t e;
        @(negedge clk);
        reset = rst;
        if (to_b) begin
            b_if.start = st; b_if.amplitude = amp_t'(amp); b_if.baseline = adc_t'(base);
            a_if.start = 1'b0;
        end else begin
            a_if.start = st; a_if.amplitude = amp_t'(amp); a_if.baseline = adc_t'(base);
            b_if.start = 1'b0;
        end
        e.chk_adc = ca; e.adc = adc_t'(ea); e.busy = eb; e.done = ed; e.pileup = ep; e.name = nm;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic a_step(input bit st, input int amp, input int base, input int ea,
                          input bit eb, input bit ed, input bit ep, input string nm);
        drive(1'b0, 1'b1, st, amp, base, 1'b1, ea, eb, ed, ep, nm);
    endtask

    task automatic b_step(input bit st, input int amp, input int base, input bit ca, input int ea,
                          input bit eb, input bit ed, input bit ep, input string nm);
        drive(1'b1, 1'b1, st, amp, base, ca, ea, eb, ed, ep, nm);
    endtask

    // Free-running tail: exact cycle of the natural end is not tabulated, only decay shape and end state.
    task automatic a_run_to_done(input int bound, input int base, input string nm);
        adc_t prev;
        int   n;
        bit   seen;
        @(negedge clk);
        a_if.start = 1'b0;
        prev = a_if.adc_data;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            if (a_if.pulse_done) begin
                seen = 1'b1;
                check({nm, ".end_adc"},  int'(a_if.adc_data), base);
                check({nm, ".end_busy"}, int'(a_if.busy), 0);
            end else begin
                check({nm, ".monotonic"}, int'(a_if.adc_data <= prev), 1);
                check({nm, ".no_pileup"}, int'(a_if.pileup), 0);
                prev = a_if.adc_data;
            end
        end
        check({nm, ".done_seen"}, int'(seen), 1);
        @(negedge clk);
        check({nm, ".done_once"}, int'(a_if.pulse_done), 0);
        check({nm, ".idle_busy"}, int'(a_if.busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.start = 1'b0; a_if.amplitude = '0; a_if.baseline = '0;
        b_if.start = 1'b0; b_if.amplitude = '0; b_if.baseline = '0;

        // Reset overrides start, then first edge after release is plain IDLE.
        drive(1'b0, 1'b0, 1'b1, 500, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "reset_over_start");
        drive(1'b0, 1'b0, 1'b0, 0,   0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "reset_hold");
        a_step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "idle_after_release");

        // Basic decay
        a_step(1'b1, 1000, 0, 1000, 1'b1, 1'b0, 1'b0, "basic_s1");
        a_step(1'b0, 0,    0, 968,  1'b1, 1'b0, 1'b0, "basic_s2");
        a_step(1'b0, 0,    0, 938,  1'b1, 1'b0, 1'b0, "basic_s3");
        a_run_to_done(400, 0, "basic_tail");

        // Pile-up
        a_step(1'b1, 1000, 0, 1000, 1'b1, 1'b0, 1'b0, "pile_s1");
        a_step(1'b0, 0,    0, 968,  1'b1, 1'b0, 1'b0, "pile_s2");
        a_step(1'b1, 500,  0, 1438, 1'b1, 1'b0, 1'b1, "pile_hit");
        a_step(1'b0, 0,    0, 1393, 1'b1, 1'b0, 1'b0, "pile_after");
        a_run_to_done(400, 0, "pile_tail");

        // Start coinciding with the natural end keeps the pulse alive
        a_step(1'b1, 1, 0, 1, 1'b1, 1'b0, 1'b0, "tiny_s1");
        a_step(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b1, "end_vs_start");
        a_step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, "end_after_pile");
        a_step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "idle_after_pile");

        // Small pulse
        a_step(1'b1, 1, 0, 1, 1'b1, 1'b0, 1'b0, "small_s1");
        a_step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, "small_end");
        a_step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "small_idle");

        // Saturation, then reset aborts the pulse without pulse_done
        a_step(1'b1, 2047, 100, 2047, 1'b1, 1'b0, 1'b0, "sat_s1");
        a_step(1'b0, 0,    100, 2047, 1'b1, 1'b0, 1'b0, "sat_s2");
        a_step(1'b0, 0,    100, 2021, 1'b1, 1'b0, 1'b0, "sat_s3");
        drive(1'b0, 1'b0, 1'b0, 0, 100, 1'b1, 0, 1'b0, 1'b0, 1'b0, "sat_reset");

        // Negative baseline, zero-amplitude start, baseline tracking
        a_step(1'b0, 0, -100,  -100,  1'b0, 1'b0, 1'b0, "neg_base_idle");
        a_step(1'b0, 0, -100,  -100,  1'b0, 1'b0, 1'b0, "neg_base_hold");
        a_step(1'b1, 0, -100,  -100,  1'b1, 1'b0, 1'b0, "zero_amp_start");
        a_step(1'b0, 0, -100,  -100,  1'b0, 1'b1, 1'b0, "zero_amp_end");
        a_step(1'b0, 0, -100,  -100,  1'b0, 1'b0, 1'b0, "zero_amp_idle");
        a_step(1'b0, 0, -2048, -2048, 1'b0, 1'b0, 1'b0, "min_base");
        a_step(1'b0, 0, 50,    50,    1'b0, 1'b0, 1'b0, "base_track");

        // Reset on the fifth decay edge, then a clean restart
        a_step(1'b1, 1000, 0, 1000, 1'b1, 1'b0, 1'b0, "rmid_s1");
        a_step(1'b0, 0,    0, 968,  1'b1, 1'b0, 1'b0, "rmid_d1");
        a_step(1'b0, 0,    0, 938,  1'b1, 1'b0, 1'b0, "rmid_d2");
        a_step(1'b0, 0,    0, 909,  1'b1, 1'b0, 1'b0, "rmid_d3");
        a_step(1'b0, 0,    0, 880,  1'b1, 1'b0, 1'b0, "rmid_d4");
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "rmid_reset");
        a_step(1'b0, 0,    0, 0,    1'b0, 1'b0, 1'b0, "rmid_release");
        a_step(1'b1, 1000, 0, 1000, 1'b1, 1'b0, 1'b0, "rmid_restart");
        a_step(1'b0, 0,    0, 968,  1'b1, 1'b0, 1'b0, "rmid_r2");
        a_step(1'b0, 0,    0, 938,  1'b1, 1'b0, 1'b0, "rmid_r3");
        a_run_to_done(400, 0, "rmid_tail");

        // Timeout on the MAX_LEN=16 instance: 16 samples, then forced end
        b_step(1'b1, 1000, 10, 1'b1, 1010, 1'b1, 1'b0, 1'b0, "to_s1");
        b_step(1'b0, 0,    10, 1'b1, 978,  1'b1, 1'b0, 1'b0, "to_s2");
        b_step(1'b0, 0,    10, 1'b1, 948,  1'b1, 1'b0, 1'b0, "to_s3");
        for (int i = 4; i <= 16; i++)
            b_step(1'b0, 0, 10, 1'b0, 0, 1'b1, 1'b0, 1'b0, "to_busy");
        b_step(1'b0, 0, 10, 1'b1, 10, 1'b0, 1'b1, 1'b0, "to_end");
        b_step(1'b0, 0, 10, 1'b1, 10, 1'b0, 1'b0, 1'b0, "to_idle");

        @(negedge clk);
        @(negedge clk);
        check("queues_drained", q_a.size() + q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
